// File: rtl/sfp_inv_lerp_pkg.sv
// Shared types for the vector inverse-lerp block.
// Contents:
//   state_e      - top-level sequencer states
//   comp_cycles  - cycles spent per component (setup + OW divide steps + finish)
package sfp_inv_lerp_pkg;

  typedef enum logic [2:0] {
    StIdle,
    StSetup,
    StDiv,
    StFin,
    StDone
  } state_e;

  // Per-component cost; total latency from accept to out_valid is N times this.
  function automatic int unsigned comp_cycles(input int unsigned ow);
    return ow + 2;
  endfunction

endpackage

// File: rtl/sfp_seq_div.sv
// Unsigned sequential restoring divider, one quotient bit per cycle, MSB first.
// Ports:
//   clk, rst     - clock, synchronous active-high reset
//   i_start      - load dividend/divisor; stepping begins the following cycle
//   i_dividend   - DW-bit unsigned dividend
//   i_divisor    - DVW-bit unsigned divisor
//   o_done       - high during the cycle that resolves the last quotient bit
//   o_quot       - QW-bit quotient, valid the cycle after o_done
// The caller guarantees dividend < divisor << QW (and DW-QW <= DVW) whenever it
// uses the quotient; otherwise the result is meaningless but the timing is fixed.
module sfp_seq_div #(
  parameter int unsigned DW  = 31,
  parameter int unsigned DVW = 17,
  parameter int unsigned QW  = 16
) (
  input  logic           clk,
  input  logic           rst,
  input  logic           i_start,
  input  logic [DW-1:0]  i_dividend,
  input  logic [DVW-1:0] i_divisor,
  output logic           o_done,
  output logic [QW-1:0]  o_quot
);

  localparam int unsigned CW = (QW > 1) ? $clog2(QW) : 1;

  logic [DVW-1:0] r_rem;
  logic [DVW-1:0] r_div;
  // Holds the unconsumed low dividend bits; quotient bits shift in at the bottom.
  logic [QW-1:0]  r_sh;
  logic [CW-1:0]  r_cnt;
  logic           r_busy;

  logic [DVW:0]   w_trial;
  logic           w_ge;
  logic [DVW-1:0] w_diff;

  always_comb begin
    w_trial = {r_rem, r_sh[QW-1]};
    w_ge    = (w_trial >= {1'b0, r_div});
    // When w_ge the difference is below r_div, so the low DVW bits are exact.
    w_diff  = w_trial[DVW-1:0] - r_div;
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      r_rem  <= '0;
      r_div  <= '0;
      r_sh   <= '0;
      r_cnt  <= '0;
      r_busy <= 1'b0;
    end else if (i_start) begin
      r_rem  <= DVW'(i_dividend[DW-1:QW]);
      r_div  <= i_divisor;
      r_sh   <= i_dividend[QW-1:0];
      r_cnt  <= '0;
      r_busy <= 1'b1;
    end else if (r_busy) begin
      r_rem <= w_ge ? w_diff : w_trial[DVW-1:0];
      r_sh  <= {r_sh[QW-2:0], w_ge};
      r_cnt <= r_cnt + CW'(1);
      if (r_cnt == CW'(QW - 1)) r_busy <= 1'b0;
    end
  end

  assign o_done = r_busy && (r_cnt == CW'(QW - 1));
  assign o_quot = r_sh;

endmodule

// File: rtl/sfp_vec_inv_lerp.sv
// Vector inverse lerp: per component t = (v - a) / (b - a) in signed fixed point.
// Components are processed 0..N-1 through one shared restoring divider.
// Ports:
//   clk, rst              - clock, synchronous active-high reset
//   in_valid / in_ready   - request handshake; a, b, v captured on accept
//   a, b, v               - N x (IW+QW) two's complement inputs
//   out_valid / out_ready - result handshake; t, dz held until consumed
//   t                     - N x (OIW+OQW) signed result
//   dz                    - per-component divide-by-zero flag (b == a)
module sfp_vec_inv_lerp
  import sfp_inv_lerp_pkg::*;
#(
  parameter int unsigned N     = 3,
  parameter int unsigned CLAMP = 0,
  parameter int unsigned IW    = 8,
  parameter int unsigned QW    = 8,
  parameter int unsigned OIW   = 2,
  parameter int unsigned OQW   = 14
) (
  input  logic                         clk,
  input  logic                         rst,
  input  logic                         in_valid,
  output logic                         in_ready,
  input  logic [N-1:0][IW+QW-1:0]      a,
  input  logic [N-1:0][IW+QW-1:0]      b,
  input  logic [N-1:0][IW+QW-1:0]      v,
  output logic                         out_valid,
  input  logic                         out_ready,
  output logic [N-1:0][OIW+OQW-1:0]    t,
  output logic [N-1:0]                 dz
);

  localparam int unsigned W  = IW + QW;
  localparam int unsigned OW = OIW + OQW;
  localparam int unsigned KW = (N > 1) ? $clog2(N) : 1;
  localparam int unsigned DW = W + 1 + OQW;
  localparam logic [OW-1:0] One    = OW'(1) << OQW;
  localparam logic [OW-1:0] PosMax = {1'b0, {(OW-1){1'b1}}};
  localparam logic [OW-1:0] NegMin = {1'b1, {(OW-1){1'b0}}};

  state_e                r_state, w_state_d;
  logic [N-1:0][W-1:0]   r_a, r_b, r_v;
  logic [KW-1:0]         r_k;
  logic                  r_neg, r_zero, r_ovf;
  logic [N-1:0][OW-1:0]  r_t;
  logic [N-1:0]          r_dz;

  logic [W-1:0]  w_ak, w_bk, w_vk;
  logic [W:0]    w_num, w_den, w_num_abs, w_den_abs;
  logic          w_cmp_ovf;
  logic          w_start, w_div_done, w_last_k;
  logic [OW-1:0] w_quot, w_res, w_final;
  logic          w_sat;

  // Component datapath: W+1-bit differences cannot overflow.
  always_comb begin
    w_ak      = r_a[r_k];
    w_bk      = r_b[r_k];
    w_vk      = r_v[r_k];
    w_num     = {w_vk[W-1], w_vk} - {w_ak[W-1], w_ak};
    w_den     = {w_bk[W-1], w_bk} - {w_ak[W-1], w_ak};
    w_num_abs = w_num[W] ? -w_num : w_num;
    w_den_abs = w_den[W] ? -w_den : w_den;
    // Quotient would need more than OW magnitude bits.
    w_cmp_ovf = {{OIW{1'b0}}, w_num_abs} >= {w_den_abs, {OIW{1'b0}}};
  end

  sfp_seq_div #(
    .DW  (DW),
    .DVW (W + 1),
    .QW  (OW)
  ) u_div (
    .clk        (clk),
    .rst        (rst),
    .i_start    (w_start),
    .i_dividend ({w_num_abs, {OQW{1'b0}}}),
    .i_divisor  (w_den_abs),
    .o_done     (w_div_done),
    .o_quot     (w_quot)
  );

  // Sign application, saturation and optional clamp of the finished quotient.
  always_comb begin
    // Negative results may reach exactly -2^(OW-1); positive ones stop at 2^(OW-1)-1.
    w_sat = r_ovf || (!r_neg && w_quot[OW-1]) ||
            (r_neg && w_quot[OW-1] && (|w_quot[OW-2:0]));
    if (r_zero) begin
      w_res = '0;
    end else if (w_sat) begin
      w_res = r_neg ? NegMin : PosMax;
    end else begin
      w_res = r_neg ? -w_quot : w_quot;
    end
    w_final = w_res;
    if (CLAMP != 0) begin
      if (w_res[OW-1])     w_final = '0;
      else if (w_res > One) w_final = One;
    end
  end

  always_comb begin
    w_state_d = r_state;
    w_start   = 1'b0;
    w_last_k  = (r_k == KW'(N - 1));
    unique case (r_state)
      StIdle:  if (in_valid) w_state_d = StSetup;
      StSetup: begin
        w_start   = 1'b1;
        w_state_d = StDiv;
      end
      StDiv:   if (w_div_done) w_state_d = StFin;
      StFin:   w_state_d = w_last_k ? StDone : StSetup;
      StDone:  if (out_ready) w_state_d = StIdle;
      default: w_state_d = StIdle;
    endcase
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      r_state <= StIdle;
      r_a     <= '0;
      r_b     <= '0;
      r_v     <= '0;
      r_k     <= '0;
      r_neg   <= 1'b0;
      r_zero  <= 1'b0;
      r_ovf   <= 1'b0;
      r_t     <= '0;
      r_dz    <= '0;
    end else begin
      r_state <= w_state_d;
      if (r_state == StIdle && in_valid) begin
        r_a  <= a;
        r_b  <= b;
        r_v  <= v;
        r_k  <= '0;
        r_dz <= '0;
      end
      if (r_state == StSetup) begin
        r_neg  <= w_num[W] ^ w_den[W];
        r_zero <= (w_den == '0);
        r_ovf  <= (w_den != '0) && w_cmp_ovf;
      end
      if (r_state == StFin) begin
        r_t[r_k]  <= w_final;
        r_dz[r_k] <= r_zero;
        if (!w_last_k) r_k <= r_k + KW'(1);
      end
    end
  end

  assign in_ready  = (r_state == StIdle);
  assign out_valid = (r_state == StDone);
  assign t         = r_t;
  assign dz        = r_dz;

endmodule

// File: tb/tb_sfp_vec_inv_lerp.sv
// Directed bench for sfp_vec_inv_lerp: N=3, Q8.8 inputs, Q2.14 outputs.
// Two instances share stimulus: CLAMP=0 (dut) and CLAMP=1 (dut_c).
module tb_sfp_vec_inv_lerp;

  localparam int N   = 3;
  localparam int W   = 16;
  localparam int OW  = 16;
  localparam int LAT = 54;

  logic clk = 1'b0;
  logic rst, in_valid, out_ready;
  logic [N-1:0][W-1:0] a, b, v;
  logic in_ready, out_valid, in_ready_c, out_valid_c;
  logic [N-1:0][OW-1:0] t, t_c;
  logic [N-1:0] dz, dz_c;

  int checks   = 0;
  int failures = 0;

  always #5 clk = ~clk;

  sfp_vec_inv_lerp #(
    .N(3), .CLAMP(0), .IW(8), .QW(8), .OIW(2), .OQW(14)
  ) dut (
    .clk(clk), .rst(rst), .in_valid(in_valid), .in_ready(in_ready),
    .a(a), .b(b), .v(v), .out_valid(out_valid), .out_ready(out_ready),
    .t(t), .dz(dz)
  );

  sfp_vec_inv_lerp #(
    .N(3), .CLAMP(1), .IW(8), .QW(8), .OIW(2), .OQW(14)
  ) dut_c (
    .clk(clk), .rst(rst), .in_valid(in_valid), .in_ready(in_ready_c),
    .a(a), .b(b), .v(v), .out_valid(out_valid_c), .out_ready(out_ready),
    .t(t_c), .dz(dz_c)
  );

  function automatic logic [2:0][15:0] vec3(input logic [15:0] c0, c1, c2);
    return {c2, c1, c0};
  endfunction

  // Present a request, wait for the accepting edge, then scramble the inputs.
  task automatic send(input logic [2:0][15:0] ia, ib, iv);
    int n = 0;
    a = ia; b = ib; v = iv; in_valid = 1'b1;
    while (!in_ready && n < 100) begin
      @(posedge clk); #1; n++;
    end
    if (!in_ready) begin
      $display("FAIL accept: in_ready=%b after %0d cycles, required 1", in_ready, n);
      $fatal(1, "request never accepted");
    end
    @(posedge clk); #1;
    in_valid = 1'b0; a = ~ia; b = ~ib; v = ~iv;
  endtask

  // Cycles from the accepting edge until out_valid; 200 means it never came.
  task automatic wait_out(output int lat);
    lat = 0;
    while (!out_valid && lat < 200) begin
      @(posedge clk); #1; lat++;
    end
  endtask

  task automatic release_out();
    out_ready = 1'b1;
    @(posedge clk); #1;
    out_ready = 1'b0;
  endtask

  task automatic test_reset();
    rst = 1'b1; in_valid = 1'b0; out_ready = 1'b0;
    a = '0; b = '0; v = '0;
    repeat (2) @(posedge clk);
    #1 rst = 1'b0;
    checks++;
    if ({in_ready, out_valid, in_ready_c, out_valid_c} !== 4'b1010) begin
      failures++;
      $display("FAIL reset_hs: in_ready/out_valid(x2)=%b, required 1010",
               {in_ready, out_valid, in_ready_c, out_valid_c});
    end
    checks++;
    if ({t, t_c} !== '0) begin
      failures++; $display("FAIL reset_t: t=%h t_c=%h, required 0", t, t_c);
    end
    checks++;
    if ({dz, dz_c} !== '0) begin
      failures++; $display("FAIL reset_dz: dz=%b dz_c=%b, required 0", dz, dz_c);
    end
  endtask

  task automatic test_midpoint();
    int lat;
    logic [2:0][15:0] et;
    et = vec3(16'h2000, 16'h2000, 16'h2000);
    send(vec3(16'h0000, 16'h0000, 16'h0000), vec3(16'h0400, 16'h0200, 16'hF800),
         vec3(16'h0200, 16'h0100, 16'hFC00));
    wait_out(lat);
    checks++;
    if (lat !== LAT || out_valid_c !== 1'b1) begin
      failures++;
      $display("FAIL mid_latency: %0d cycles (clamp out_valid=%b), required %0d", lat,
               out_valid_c, LAT);
    end
    checks++;
    if (t !== et) begin failures++; $display("FAIL mid_t: t=%h, required %h", t, et); end
    checks++;
    if (dz !== 3'b000) begin failures++; $display("FAIL mid_dz: dz=%b, required 000", dz); end
    checks++;
    if (t_c !== et || dz_c !== 3'b000) begin
      failures++; $display("FAIL mid_clamp: t_c=%h dz_c=%b, required %h 000", t_c, dz_c, et);
    end
    release_out();
    checks++;
    if (in_ready !== 1'b1 || out_valid !== 1'b0) begin
      failures++;
      $display("FAIL mid_release: in_ready=%b out_valid=%b, required 1 0", in_ready, out_valid);
    end
  endtask

  task automatic test_sign_trunc();
    int lat;
    logic [2:0][15:0] et, etc;
    // 1/3 truncated, -1/3, and exactly -2.0 (most negative representable).
    et  = vec3(16'h1555, 16'hEAAB, 16'h8000);
    etc = vec3(16'h1555, 16'h0000, 16'h0000);
    send(vec3(16'h0100, 16'h0100, 16'h0000), vec3(16'h0400, 16'h0400, 16'h0100),
         vec3(16'h0200, 16'h0000, 16'hFE00));
    wait_out(lat);
    checks++;
    if (lat !== LAT) begin
      failures++; $display("FAIL sign_latency: %0d cycles, required %0d", lat, LAT);
    end
    checks++;
    if (t !== et) begin failures++; $display("FAIL sign_t: t=%h, required %h", t, et); end
    checks++;
    if (dz !== 3'b000) begin failures++; $display("FAIL sign_dz: dz=%b, required 000", dz); end
    checks++;
    if (t_c !== etc) begin
      failures++; $display("FAIL sign_clamp: t_c=%h, required %h", t_c, etc);
    end
    release_out();
    checks++;
    if (in_ready !== 1'b1 || out_valid !== 1'b0) begin
      failures++;
      $display("FAIL sign_release: in_ready=%b out_valid=%b, required 1 0", in_ready, out_valid);
    end
  endtask

  task automatic test_dz_ovf();
    int lat;
    logic [2:0][15:0] et, etc;
    // 100/0.25 overflows; b==a on component 1; 3.0/1.0 exceeds the signed range.
    et  = vec3(16'h7FFF, 16'h0000, 16'h7FFF);
    etc = vec3(16'h4000, 16'h0000, 16'h4000);
    send(vec3(16'h0000, 16'h0300, 16'h0000), vec3(16'h0040, 16'h0300, 16'h0100),
         vec3(16'h6400, 16'h0500, 16'h0300));
    wait_out(lat);
    checks++;
    if (lat !== LAT) begin
      failures++; $display("FAIL dzovf_latency: %0d cycles, required %0d", lat, LAT);
    end
    checks++;
    if (t !== et) begin failures++; $display("FAIL dzovf_t: t=%h, required %h", t, et); end
    checks++;
    if (dz !== 3'b010 || dz_c !== 3'b010) begin
      failures++; $display("FAIL dzovf_dz: dz=%b dz_c=%b, required 010", dz, dz_c);
    end
    checks++;
    if (t_c !== etc) begin
      failures++; $display("FAIL dzovf_clamp: t_c=%h, required %h", t_c, etc);
    end
    release_out();
    checks++;
    if (in_ready !== 1'b1 || out_valid !== 1'b0) begin
      failures++;
      $display("FAIL dzovf_release: in_ready=%b out_valid=%b, required 1 0", in_ready, out_valid);
    end
  endtask

  task automatic test_back_to_back();
    int lat;
    logic [2:0][15:0] et1, et2;
    et1 = vec3(16'h1555, 16'hEAAB, 16'h8000);
    et2 = vec3(16'h7FFF, 16'h0000, 16'h7FFF);
    send(vec3(16'h0100, 16'h0100, 16'h0000), vec3(16'h0400, 16'h0400, 16'h0100),
         vec3(16'h0200, 16'h0000, 16'hFE00));
    wait_out(lat);
    checks++;
    if (lat !== LAT) begin
      failures++; $display("FAIL bp_latency: %0d cycles, required %0d", lat, LAT);
    end
    // Second request waits on the inputs while the first result is held.
    a = vec3(16'h0000, 16'h0300, 16'h0000);
    b = vec3(16'h0040, 16'h0300, 16'h0100);
    v = vec3(16'h6400, 16'h0500, 16'h0300);
    in_valid = 1'b1;
    for (int i = 0; i < 20; i++) begin
      @(posedge clk); #1;
      checks++;
      if (t !== et1 || dz !== 3'b000 || in_ready !== 1'b0 || out_valid !== 1'b1) begin
        failures++;
        $display("FAIL bp_hold[%0d]: t=%h dz=%b in_ready=%b out_valid=%b, required %h 000 0 1",
                 i, t, dz, in_ready, out_valid, et1);
      end
    end
    release_out();
    checks++;
    if (in_ready !== 1'b1 || out_valid !== 1'b0) begin
      failures++;
      $display("FAIL bp_release: in_ready=%b out_valid=%b, required 1 0", in_ready, out_valid);
    end
    send(vec3(16'h0000, 16'h0300, 16'h0000), vec3(16'h0040, 16'h0300, 16'h0100),
         vec3(16'h6400, 16'h0500, 16'h0300));
    wait_out(lat);
    checks++;
    if (lat !== LAT) begin
      failures++; $display("FAIL b2b_latency: %0d cycles, required %0d", lat, LAT);
    end
    checks++;
    if (t !== et2 || dz !== 3'b010) begin
      failures++; $display("FAIL b2b_result: t=%h dz=%b, required %h 010", t, dz, et2);
    end
    release_out();
  endtask

  task automatic test_reset_mid_div();
    int lat;
    logic [2:0][15:0] et;
    et = vec3(16'h2000, 16'h2000, 16'h2000);
    send(vec3(16'h0100, 16'h0100, 16'h0000), vec3(16'h0400, 16'h0400, 16'h0100),
         vec3(16'h0200, 16'h0000, 16'hFE00));
    repeat (9) @(posedge clk);
    #1 rst = 1'b1;
    @(posedge clk);
    #1 rst = 1'b0;
    checks++;
    if (out_valid !== 1'b0 || in_ready !== 1'b1) begin
      failures++;
      $display("FAIL rstdiv_hs: out_valid=%b in_ready=%b, required 0 1", out_valid, in_ready);
    end
    checks++;
    if (t !== '0 || dz !== '0 || t_c !== '0) begin
      failures++;
      $display("FAIL rstdiv_t: t=%h dz=%b t_c=%h, required 0", t, dz, t_c);
    end
    send(vec3(16'h0000, 16'h0000, 16'h0000), vec3(16'h0400, 16'h0200, 16'hF800),
         vec3(16'h0200, 16'h0100, 16'hFC00));
    wait_out(lat);
    checks++;
    if (lat !== LAT) begin
      failures++; $display("FAIL rstdiv_latency: %0d cycles, required %0d", lat, LAT);
    end
    checks++;
    if (t !== et || dz !== 3'b000) begin
      failures++; $display("FAIL rstdiv_result: t=%h dz=%b, required %h 000", t, dz, et);
    end
    release_out();
  endtask

  initial begin
    test_reset();
    test_midpoint();
    test_sign_trunc();
    test_dz_ovf();
    test_back_to_back();
    test_reset_mid_div();
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule

// File: doc/sfp_vec_inv_lerp.md
Name: sfp_vec_inv_lerp

Overview:
Inverse of the vector lerp. Per component it computes t = (v - a) / (b - a), so that lerp(a, b, t) = v. The block uses one shared sequential restoring divider. Components are processed in order 0..N-1, with a valid/ready handshake on both the input and output sides. It sits after the shading/intersection datapath, where the renderer recovers interpolation parameters from fixed-point positions or colours.

Parameters:
N, 3, vector component count
CLAMP, 0, 1 = clamp each result to [0.0, 1.0]; 0 = saturate to the full output range only

Ports:
clk  in  1  clock
rst  in  1  synchronous, active-high reset
in_valid  in  1  a/b/v hold a valid request
in_ready  out  1  block can accept a request
a  in  sfp_if.in[N] (a.IW+a.QW each)  lerp start point
b  in  sfp_if.in[N] (same format as a)  lerp end point
v  in  sfp_if.in[N] (same format as a)  interpolated value
out_valid  out  1  t and dz are valid
out_ready  in  1  consumer accepts the result
t  out  sfp_if.out[N] (OIW+OQW each, from t.IW/t.QW)  recovered parameter, signed
dz  out  N  per-component divide-by-zero flag (b == a)

Behaviour:
- Notation: W = IW+QW (input width), OW = OIW+OQW (output width). All values are two's complement.
- Reset: state = IDLE, in_ready = 1, out_valid = 0, every t = 0, dz = 0. Reset takes effect in any state; an in-flight transaction is dropped with no output.
- States: IDLE, SETUP, DIV, FIN, DONE. A component index k counts 0..N-1.
- IDLE:
  - in_ready = 1.
  - On in_valid && in_ready, register all a, b, v; set k = 0; go to SETUP.
  - in_ready is 0 in every other state.
- SETUP (1 cycle):
  - num = v[k] - a[k] and den = b[k] - a[k], each W+1 bits, so there is no overflow.
  - neg = sign(num) XOR sign(den).
  - Load |num|, |den| into the divider.
  - zero = (den == 0).
  - ovf = (|num| >= |den| << OIW), evaluated only when den != 0.
  - Go to DIV with iteration count 0.
- DIV (exactly OW cycles):
  - One restoring-division quotient bit per cycle, MSB first.
  - Result q = floor(|num| * 2^OQW / |den|), i.e. truncation toward zero on the magnitude.
  - The cycle count is fixed regardless of zero or ovf.
- FIN (1 cycle):
  - If zero: t[k] = 0 and dz[k] = 1.
  - Else if ovf or q exceeds the signed range: t[k] = +max (neg = 0) or -min (neg = 1).
  - Else t[k] = neg ? -q : q.
  - If CLAMP = 1, clamp the result to [0, 1 << OQW]. Because this clamps to 1.0, OIW must be >= 2 when CLAMP = 1.
  - If k == N-1, go to DONE; else k++ and go to SETUP.
- Latency: out_valid rises exactly N*(OW+2) cycles after the accepting edge.
- DONE:
  - out_valid = 1.
  - t and dz are held stable until out_ready.
  - On out_valid && out_ready, go to IDLE. The next accept can occur on the following cycle, so there is no same-cycle bypass.
- t[k] and dz[k] registers are updated only in FIN. dz is cleared on accept.
- Changes on the input ports after accept have no effect on the transaction.

Decomposition:
- Package sfp_inv_lerp_pkg holds:
  - state enum (IDLE/SETUP/DIV/FIN/DONE)
  - a localparam function for the per-component cycle count (OW+2)
- Sub-module sfp_seq_div: unsigned restoring divider with start/busy/done, parameterised by dividend width, divisor width and quotient width OW. It is instantiated once and shared across components.

Test Plan:
All scenarios use N=3, inputs IW=8 QW=8, output IW=2 QW=14, so OW = 16 and latency = 54.

1. Midpoint: a = (0,0,0), b = (4.0,2.0,-8.0), v = (2.0,1.0,-4.0) -> t = 0.5 each (0x2000); dz = 0; out_valid exactly 54 cycles after accept.
2. Sign, truncation and extrapolation: a = 1.0, b = 4.0, v = 2.0 -> t = 0x1555 (truncated 1/3). v = 0.0 with the same a, b -> t = -0x1555. With CLAMP = 1, the same negative case -> t = 0.
3. Divide by zero and overflow: a = b = 3.0, v = 5.0 -> t = 0, dz = 1 on that component only. a = 0, b = 0.25, v = 100.0 -> t = 0x7FFF (saturated).
4. Backpressure: hold out_ready = 0 for 20 cycles -> t/dz stable, in_ready = 0, new in_valid ignored. Pulsing out_ready -> IDLE the next cycle. A back-to-back second request completes correctly.
5. Reset mid-DIV (cycle 10 after accept) -> the next cycle shows out_valid = 0, in_ready = 1, t = 0. A following request produces correct results with no residue from the dropped transaction.
